// File: rtl/cu_pkg.sv
// Shared constants, decode classes and FSM state encoding for the multicycle control unit.
package cu_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_SUB   = 7'b0100000;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;

    typedef enum logic [1:0] {
        CLS_ILLEGAL = 2'd0,
        CLS_RTYPE   = 2'd1,
        CLS_LOAD    = 2'd2
    } instr_class_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_WB       = 3'd4
    } cu_state_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction classifier: opcode/func fields to {class, alu_op}.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int WIDTH_OP = 7
) (
    input  logic [WIDTH_OP-1:0] opcode,
    input  logic [2:0]          func3,
    input  logic [WIDTH_OP-1:0] func7,
    output instr_class_t        instr_class,
    output logic [3:0]          alu_op
);

    always_comb begin
        instr_class = CLS_ILLEGAL;
        alu_op      = ALU_NONE;
        if (opcode == WIDTH_OP'(OP_RTYPE)) begin
            if (func7 == WIDTH_OP'(F7_SUB)) begin
                instr_class = CLS_RTYPE;
                alu_op      = ALU_SUB;
            end else if (func7 == WIDTH_OP'(F7_BASE)) begin
                // func3 codes outside the supported set stay illegal
                case (func3)
                    3'b000: begin instr_class = CLS_RTYPE; alu_op = ALU_ADD; end
                    3'b100: begin instr_class = CLS_RTYPE; alu_op = ALU_XOR; end
                    3'b110: begin instr_class = CLS_RTYPE; alu_op = ALU_OR;  end
                    3'b111: begin instr_class = CLS_RTYPE; alu_op = ALU_AND; end
                    default: begin instr_class = CLS_ILLEGAL; alu_op = ALU_NONE; end
                endcase
            end
        end else if (opcode == WIDTH_OP'(OP_LOAD)) begin
            instr_class = CLS_LOAD;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle instruction sequencer: decode, optional load wait with timeout,
// single-cycle write-back and a wrapping retired-instruction counter.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | instr_ready high, waiting for instr_valid
// ST_DECODE   | class/alu_op registered; illegal returns to idle with err
// ST_EXEC     | R-type heads to write-back, load raises mem_req
// ST_MEM_WAIT | mem_req held; ack or timeout counter terminal count exits
// ST_WB       | reg_wen pulse, retired already bumped, back to idle
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int WIDTH_OP    = 7,
    parameter int XLEN        = 32,
    parameter int IMM_W       = 20,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [WIDTH_OP-1:0] opcode,
    input  logic [2:0]          func3,
    input  logic [WIDTH_OP-1:0] func7,
    input  logic [IMM_W-1:0]    immidiate_data,
    output logic                mem_req,
    input  logic                mem_ack,
    output logic                reg_wen,
    output logic                reg_flag,
    output logic [3:0]          alu_op,
    output logic [XLEN-1:0]     load_data,
    output logic                err,
    output logic                busy,
    output logic [CNT_W-1:0]    retired
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    cu_state_t          state;
    instr_class_t       cls_q;
    instr_class_t       dec_class;
    logic [3:0]         dec_alu_op;
    logic [IMM_W-1:0]   imm_q;
    logic [TMO_W-1:0]   tmo_cnt;

    // Decoding the live fields at capture lets err and alu_op be registered
    // outputs that are already valid during the DECODE cycle.
    cu_decoder #(
        .WIDTH_OP (WIDTH_OP)
    ) u_decoder (
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .instr_class (dec_class),
        .alu_op      (dec_alu_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cls_q       <= CLS_ILLEGAL;
            imm_q       <= '0;
            tmo_cnt     <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            mem_req     <= 1'b0;
            reg_wen     <= 1'b0;
            reg_flag    <= 1'b0;
            err         <= 1'b0;
            alu_op      <= ALU_NONE;
            load_data   <= '0;
            retired     <= '0;
        end else begin
            reg_wen <= 1'b0;
            err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        imm_q       <= immidiate_data;
                        cls_q       <= dec_class;
                        alu_op      <= dec_alu_op;
                        err         <= (dec_class == CLS_ILLEGAL);
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (cls_q == CLS_ILLEGAL) begin
                        alu_op      <= ALU_NONE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cls_q == CLS_LOAD) begin
                        mem_req <= 1'b1;
                        tmo_cnt <= TMO_W'(MEM_TIMEOUT - 1);
                        state   <= ST_MEM_WAIT;
                    end else begin
                        reg_wen  <= 1'b1;
                        reg_flag <= 1'b0;
                        retired  <= retired + CNT_W'(1);
                        state    <= ST_WB;
                    end
                end
                ST_MEM_WAIT: begin
                    // ack is tested first so it wins on the terminal-count cycle
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        load_data <= XLEN'(imm_q);
                        reg_wen   <= 1'b1;
                        reg_flag  <= 1'b1;
                        retired   <= retired + CNT_W'(1);
                        tmo_cnt   <= '0;
                        state     <= ST_WB;
                    end else if (tmo_cnt == '0) begin
                        mem_req     <= 1'b0;
                        err         <= 1'b1;
                        alu_op      <= ALU_NONE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                ST_WB: begin
                    alu_op      <= ALU_NONE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    mem_req     <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: stimulus pushes expected write-back/err events, a monitor pops them.
module tb_multicycle_control_unit;

    localparam int WIDTH_OP    = 7;
    localparam int XLEN        = 32;
    localparam int IMM_W       = 20;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                instr_valid = 1'b0;
    logic                instr_ready;
    logic [WIDTH_OP-1:0] opcode = '0;
    logic [2:0]          func3 = '0;
    logic [WIDTH_OP-1:0] func7 = '0;
    logic [IMM_W-1:0]    immidiate_data = '0;
    logic                mem_req;
    logic                mem_ack = 1'b0;
    logic                reg_wen;
    logic                reg_flag;
    logic [3:0]          alu_op;
    logic [XLEN-1:0]     load_data;
    logic                err;
    logic                busy;
    logic [CNT_W-1:0]    retired;

    multicycle_control_unit #(
        .WIDTH_OP    (WIDTH_OP),
        .XLEN        (XLEN),
        .IMM_W       (IMM_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .opcode         (opcode),
        .func3          (func3),
        .func7          (func7),
        .immidiate_data (immidiate_data),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .reg_wen        (reg_wen),
        .reg_flag       (reg_flag),
        .alu_op         (alu_op),
        .load_data      (load_data),
        .err            (err),
        .busy           (busy),
        .retired        (retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          is_err;
        int          at;
        logic [3:0]  alu;
        bit          flag;
        logic [31:0] ld;
    } exp_t;

    exp_t expq[$];
    int checks = 0;
    int errors = 0;
    int model_ret = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference decode straight from the instruction-set rules: class 0 illegal, 1 R-type, 2 load.
    function automatic void model_decode(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7, output int cls, output logic [3:0] alu);
        cls = 0;
        alu = 4'd0;
        if (op == 7'b0110011 && f7 == 7'b0100000) begin
            cls = 1; alu = 4'd2;
        end else if (op == 7'b0110011 && f7 == 7'b0000000) begin
            case (f3)
                3'b000: begin cls = 1; alu = 4'd1; end
                3'b100: begin cls = 1; alu = 4'd5; end
                3'b110: begin cls = 1; alu = 4'd3; end
                3'b111: begin cls = 1; alu = 4'd4; end
                default: begin cls = 0; alu = 4'd0; end
            endcase
        end else if (op == 7'b0000011) begin
            cls = 2;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (reg_wen || err)) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: reg_wen=%0b err=%0b with nothing expected (cycle %0d)",
                         reg_wen, err, cyc);
            end else begin
                e = expq.pop_front();
                check("event_cycle", 64'(cyc), 64'(e.at));
                check("err_pulse", 64'(err), 64'(e.is_err));
                check("reg_wen_pulse", 64'(reg_wen), 64'(!e.is_err));
                if (!e.is_err) begin
                    check("alu_op", 64'(alu_op), 64'(e.alu));
                    check("reg_flag", 64'(reg_flag), 64'(e.flag));
                    if (e.flag) check("load_data", 64'(load_data), 64'(e.ld));
                end
            end
        end
    end

    // Runs one instruction; ack_k < 15 acks in MEM_WAIT cycle ack_k, otherwise no ack.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [19:0] imm, input int ack_k);
        int n = 0;
        int c, last, cls, hold_end;
        logic [3:0] alu;
        exp_t e;
        while (!instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(instr_ready), 64'd1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        c = cyc;
        opcode = op; func3 = f3; func7 = f7; immidiate_data = imm;
        instr_valid = 1'b1;
        model_decode(op, f3, f7, cls, alu);
        e.alu = alu; e.flag = 1'b0; e.ld = 32'd0; e.is_err = 1'b0;
        hold_end = 0;
        if (cls == 0) begin
            e.is_err = 1'b1; e.at = c + 1; last = c + 1;
        end else if (cls == 1) begin
            e.at = c + 3; last = c + 3;
            model_ret = (model_ret + 1) % (1 << CNT_W);
        end else if (ack_k < MEM_TIMEOUT) begin
            e.flag = 1'b1; e.ld = {12'd0, imm}; e.at = c + 4 + ack_k; last = c + 4 + ack_k;
            hold_end = c + 3 + ack_k;
            model_ret = (model_ret + 1) % (1 << CNT_W);
        end else begin
            e.is_err = 1'b1; e.at = c + 3 + MEM_TIMEOUT; last = c + 3 + MEM_TIMEOUT;
            hold_end = c + 2 + MEM_TIMEOUT;
        end
        expq.push_back(e);
        for (int t = c + 1; t <= last; t++) begin
            @(negedge clk);
            instr_valid = (t == last) ? 1'b0 : 1'($urandom_range(0, 1));
            opcode = 7'($urandom); func3 = 3'($urandom); func7 = 7'($urandom);
            immidiate_data = 20'($urandom);
            mem_ack = (cls == 2 && ack_k < MEM_TIMEOUT && t == c + 3 + ack_k);
            if (cls == 2 && t >= c + 3 && t <= hold_end) check("mem_req_held", 64'(mem_req), 64'd1);
            if (cls == 2 && t == last) check("mem_req_dropped", 64'(mem_req), 64'd0);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        instr_valid = 1'b0;
        check("ready_after", 64'(instr_ready), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("retired", 64'(retired), 64'(model_ret));
    endtask

    task automatic run_random();
        int kind;
        logic [6:0] op, f7;
        logic [2:0] f3;
        kind = $urandom_range(0, 6);
        op = 7'b0110011; f7 = 7'b0000000; f3 = 3'($urandom);
        case (kind)
            0: f3 = 3'b000;
            1: f3 = 3'b100;
            2: f3 = 3'b110;
            3: f3 = 3'b111;
            4: f7 = 7'b0100000;
            5: begin op = 7'b0000011; f7 = 7'($urandom); end
            default: begin
                case ($urandom_range(0, 2))
                    0: op = 7'($urandom);
                    1: f3 = 3'($urandom_range(1, 3));
                    default: f7 = 7'($urandom_range(1, 31));
                endcase
            end
        endcase
        run_instr(op, f3, f7, 20'($urandom), int'($urandom_range(0, 16)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        repeat (3) @(negedge clk);
        check("rst_reg_wen", 64'(reg_wen), 64'd0);
        check("rst_reg_flag", 64'(reg_flag), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_load_data", 64'(load_data), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(instr_ready), 64'd1);

        run_instr(7'b0110011, 3'b000, 7'b0000000, 20'h12345, 0);  // ADD
        run_instr(7'b0110011, 3'b101, 7'b0100000, 20'h00001, 0);  // SUB
        run_instr(7'b0110011, 3'b100, 7'b0000000, 20'h00002, 0);  // XOR
        run_instr(7'b0110011, 3'b110, 7'b0000000, 20'h00003, 0);  // OR
        run_instr(7'b0110011, 3'b111, 7'b0000000, 20'h00004, 0);  // AND
        run_instr(7'b0000011, 3'b010, 7'b0000000, 20'hABCDE, 2);  // load, ack after 2
        run_instr(7'b0010011, 3'b000, 7'b0000000, 20'h00005, 0);  // illegal
        run_instr(7'b0000011, 3'b010, 7'b0000000, 20'h0FFFF, 15); // timeout
        run_instr(7'b0000011, 3'b010, 7'b0000000, 20'hFEDCB, 14); // ack on terminal cycle
        run_instr(7'b0110011, 3'b001, 7'b0000000, 20'h00006, 0);  // unsupported func3
        run_instr(7'b0000011, 3'b000, 7'b0000000, 20'h54321, 0);  // ack in first wait cycle
        for (int i = 0; i < 40; i++) run_random();

        // reset while a load is waiting on memory
        c = 0;
        while (!instr_ready && c < 40) begin
            @(negedge clk);
            c++;
        end
        opcode = 7'b0000011; func3 = 3'b010; func7 = 7'b0; immidiate_data = 20'h13579;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mem_req_before_rst", 64'(mem_req), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_mem_req", 64'(mem_req), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_retired", 64'(retired), 64'd0);
        check("rst_mid_load_data", 64'(load_data), 64'd0);
        check("rst_mid_alu_op", 64'(alu_op), 64'd0);
        model_ret = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_mid_rst", 64'(instr_ready), 64'd1);
        check("busy_after_mid_rst", 64'(busy), 64'd0);
        run_instr(7'b0110011, 3'b000, 7'b0000000, 20'h00007, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
